freq_meter: RTL

- Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of clk_i cycles.
- Default window is 1 s at a 100 MHz clk_i, so the count equals the frequency in Hz.
- Sits between the external signal input and the counter/display path. Its clk_i is the same system clock that feeds clock_division.
- Latches each completed measurement and pulses a valid strobe. Runs continuously while enabled.

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/freq_meter_sync_edge_detect.sv | 28 ++
 rtl/freq_meter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter and the display/BCD path that consumes its count.
package freq_meter_pkg;

    localparam int GATE_CYCLES_DEF = 100_000_000;
    localparam int CNT_W_DEF       = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// Synchronizes an asynchronous input into the clk_i domain and flags its rising edges.
// Reusable for any slow asynchronous input such as buttons.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Synchronizer chain followed by one delay flop for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise_o = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of sig_i over a fixed gate window and latches each result with a valid strobe.
// One dead (LATCH) cycle separates back-to-back windows.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             hold_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] freq_o,
    output logic             ovf_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0]    GATE_ONE  = GW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GW-1:0]    r_gate_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_int;
    logic [CNT_W-1:0] r_freq;
    logic             r_ovf;
    logic             r_valid;
    logic             r_busy;
    logic             w_rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig_i (sig_i),
        .rise_o(w_rise)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping en_i beats window close
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en_i) w_state_nxt = ST_GATE;
                else      w_state_nxt = ST_IDLE;
            end
            ST_GATE: begin
                if (!en_i)                        w_state_nxt = ST_IDLE;
                else if (r_gate_cnt == GATE_LAST) w_state_nxt = ST_LATCH;
                else                              w_state_nxt = ST_GATE;
            end
            ST_LATCH: begin
                if (en_i) w_state_nxt = ST_GATE;
                else      w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gate and saturating edge counters; cleared outside the window
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
        end else begin
            case (r_state)
                ST_GATE: begin
                    r_gate_cnt <= r_gate_cnt + GATE_ONE;
                    if (w_rise) begin
                        if (r_edge_cnt == CNT_MAX) r_ovf_int  <= 1'b1;
                        else                       r_edge_cnt <= r_edge_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_ovf_int  <= 1'b0;
                end
            endcase
        end
    end

    // Registered result, strobe and busy flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_freq  <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == ST_GATE);
            if ((r_state == ST_LATCH) && !hold_i) begin
                r_freq  <= r_edge_cnt;
                r_ovf   <= r_ovf_int;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign freq_o  = r_freq;
    assign ovf_o   = r_ovf;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;

endmodule
